// File: rtl/full_adder_bit.sv
// Single-bit full-adder slice; the leaf cell chained by full_adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with combinational and registered results.
// Optional sticky result checker on port err when FULL_ADDER_CHECK_EN is defined.
module full_adder #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_out_q,
    output logic             out_valid
`ifdef FULL_ADDER_CHECK_EN
    ,
    output logic             err
`endif
);

    logic [WIDTH:0] carry;

    assign carry[0] = carry_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        full_adder_bit u_bit (
            .a         (a[i]),
            .b         (b[i]),
            .carry_in  (carry[i]),
            .sum       (sum[i]),
            .carry_out (carry[i+1])
        );
    end

    assign carry_out = carry[WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            out_valid   <= 1'b0;
        end else if (in_valid) begin
            sum_q       <= sum;
            carry_out_q <= carry_out;
            out_valid   <= 1'b1;
        end else begin
            out_valid   <= 1'b0;
        end
    end

`ifdef FULL_ADDER_CHECK_EN
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_in_q;
    logic [WIDTH:0]   check_sum;

    // Reference is recomputed from the captured operands, independent of the slice chain.
    assign check_sum = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, carry_in_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            carry_in_q <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (in_valid) begin
                a_q        <= a;
                b_q        <= b;
                carry_in_q <= carry_in;
            end
            if (out_valid && (check_sum != {carry_out_q, sum_q})) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: literal pins plus a per-cycle arithmetic model.
module tb_full_adder;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n = 1'b0;

    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic       s1, co1;

    logic [7:0] a8 = '0, b8 = '0;
    logic       c8 = 1'b0, in_valid = 1'b0;
    logic [7:0] s8, sq8;
    logic       co8, coq8, ov8;
`ifdef FULL_ADDER_CHECK_EN
    logic       err1, err8;
`endif
    logic       sq1, coq1, ov1;

    int unsigned checks = 0;
    int unsigned passes = 0;
    logic        cmp_en = 1'b0;

    // Model of the registered path, derived only from the input stream.
    logic [7:0] m_sum_q = '0;
    logic       m_co_q = 1'b0;
    logic       m_valid = 1'b0;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk(1'b0), .rst_n(1'b0), .a(a1), .b(b1), .carry_in(c1), .in_valid(1'b0),
        .sum(s1), .carry_out(co1), .sum_q(sq1), .carry_out_q(coq1), .out_valid(ov1)
`ifdef FULL_ADDER_CHECK_EN
        , .err(err1)
`endif
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .carry_in(c8), .in_valid(in_valid),
        .sum(s8), .carry_out(co8), .sum_q(sq8), .carry_out_q(coq8), .out_valid(ov8)
`ifdef FULL_ADDER_CHECK_EN
        , .err(err8)
`endif
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_sum_q = '0;
            m_co_q  = 1'b0;
            m_valid = 1'b0;
        end else if (in_valid) begin
            {m_co_q, m_sum_q} = 9'(a8) + 9'(b8) + 9'(c8);
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [8:0] e;
            e = 9'(a8) + 9'(b8) + 9'(c8);
            check("comb_sum", 32'(s8), 32'(e[7:0]));
            check("comb_carry", 32'(co8), 32'(e[8]));
            check("sum_q", 32'(sq8), 32'(m_sum_q));
            check("carry_out_q", 32'(coq8), 32'(m_co_q));
            check("out_valid", 32'(ov8), 32'(m_valid));
`ifdef FULL_ADDER_CHECK_EN
            check("err", 32'(err8), 32'd0);
`endif
        end
    end

    initial begin
        logic [15:0] tbl;
        tbl = 16'b00_01_01_10_01_10_10_11;

        // 1-bit truth table with no clock running and reset asserted
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = 3'(i);
            #2;
            check("tt1", 32'({co1, s1}), 32'(tbl[15 - 2*i -: 2]));
        end

        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
        #2;
        check("ff_0_1_sum", 32'(s8), 32'h00);
        check("ff_0_1_carry", 32'(co8), 32'd1);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        #2;
        check("ff_ff_1_sum", 32'(s8), 32'hFF);
        check("ff_ff_1_carry", 32'(co8), 32'd1);

        clk_en = 1'b1;
        rst_n = 1'b0; in_valid = 1'b0;
        step();
        cmp_en = 1'b1;
        step();

        rst_n = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; in_valid = 1'b1;
        step();
        check("first_sum_q", 32'(sq8), 32'h46);
        check("first_carry_q", 32'(coq8), 32'd0);
        check("first_valid", 32'(ov8), 32'd1);
        in_valid = 1'b0;
        step();
        check("idle_valid", 32'(ov8), 32'd0);
        check("idle_hold", 32'(sq8), 32'h46);

        in_valid = 1'b1; b8 = 8'd1; a8 = 8'd1;
        step();
        check("stream1", 32'({ov8, sq8}), 32'h102);
        a8 = 8'd2;
        step();
        check("stream2", 32'({ov8, sq8}), 32'h103);
        a8 = 8'd3; rst_n = 1'b0;
        step();
        check("stream_rst", 32'({ov8, coq8, sq8}), 32'h000);
        rst_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0: a8 = 8'hFF;
                1: a8 = 8'h00;
                default: a8 = 8'($urandom);
            endcase
            b8 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            c8 = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 31) != 0);
            step();
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
